apb_rr_master: RTL

- Two-requester APB master with round-robin arbitration; sequences IDLE/SETUP/ACCESS phases onto a single APB bus shared by downstream APB slaves.
- Accepts one command per grant, drives the APB bus, and returns read data/completion to the granted requester.
- Supports our slaves' registered PRDATA, which is valid one cycle after the completing ACCESS edge.

---
 rtl/apb_rr_master.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/apb_rr_master.sv
// apb_rr_master: two-requester round-robin APB master, one transfer in flight.
// Define APB_TIMEOUT_EN to abort ACCESS phases that stall for TIMEOUT_CYC cycles.
module apb_rr_master #(
  parameter int AW          = 8,
  parameter int DW          = 32,
  parameter int RDATA_LAT   = 1,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic            PCLK,
  input  logic            PRESETn,
  input  logic [1:0]      req_valid,
  input  logic [1:0]      req_write,
  input  logic [2*AW-1:0] req_addr,
  input  logic [2*DW-1:0] req_wdata,
  output logic [1:0]      req_ready,
  output logic [1:0]      rsp_valid,
  output logic [DW-1:0]   rsp_rdata,
  output logic            rsp_err,
  output logic            PSEL,
  output logic            PENABLE,
  output logic            PWRITE,
  output logic [AW-1:0]   PADDR,
  output logic [DW-1:0]   PWDATA,
  input  logic [DW-1:0]   PRDATA,
  input  logic            PREADY
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_ACCESS,
    S_RDWAIT
  } state_t;

  localparam bit RD_REG = (RDATA_LAT != 0);

  state_t          state_q, state_d;
  logic            last_q, last_d;
  logic            owner_q, owner_d;
  logic            psel_q, psel_d;
  logic            penable_q, penable_d;
  logic            pwrite_q, pwrite_d;
  logic [AW-1:0]   paddr_q, paddr_d;
  logic [DW-1:0]   pwdata_q, pwdata_d;
  logic [1:0]      rsp_valid_q, rsp_valid_d;
  logic [DW-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic            rsp_err_q, rsp_err_d;

`ifdef APB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0]   cnt_q, cnt_d;
`endif

  logic            grant;
  logic            win;
  logic [1:0]      owner_vec;

  // Round-robin pick; no grant while a response is being returned
  always_comb begin
    win   = (req_valid == 2'b11) ? ~last_q : req_valid[1];
    grant = (state_q == S_IDLE) && (rsp_valid_q == 2'b00)
            && (req_valid != 2'b00);
  end

  assign owner_vec = owner_q ? 2'b10 : 2'b01;
  assign req_ready = grant ? (win ? 2'b10 : 2'b01) : 2'b00;

  // Next-state and registered-output computation
  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    owner_d     = owner_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    rsp_valid_d = 2'b00;
    rsp_rdata_d = '0;
    rsp_err_d   = 1'b0;
`ifdef APB_TIMEOUT_EN
    cnt_d       = cnt_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (grant) begin
          state_d  = S_SETUP;
          last_d   = win;
          owner_d  = win;
          pwrite_d = win ? req_write[1] : req_write[0];
          paddr_d  = win ? req_addr[AW +: AW] : req_addr[0 +: AW];
          pwdata_d = win ? req_wdata[DW +: DW] : req_wdata[0 +: DW];
        end
      end
      S_SETUP: begin
        state_d = S_ACCESS;
`ifdef APB_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      S_ACCESS: begin
        if (PREADY) begin
          if (!pwrite_q && RD_REG) begin
            state_d = S_RDWAIT;
          end else begin
            state_d     = S_IDLE;
            rsp_valid_d = owner_vec;
            rsp_rdata_d = pwrite_q ? '0 : PRDATA;
          end
        end
`ifdef APB_TIMEOUT_EN
        else begin
          cnt_d = cnt_q + TW'(1);
          if (cnt_d == TW'(TIMEOUT_CYC)) begin
            state_d     = S_IDLE;
            rsp_valid_d = owner_vec;
            rsp_err_d   = 1'b1;
          end
        end
`endif
      end
      S_RDWAIT: begin
        state_d     = S_IDLE;
        rsp_valid_d = owner_vec;
        rsp_rdata_d = PRDATA;
      end
      default: state_d = S_IDLE;
    endcase
    psel_d    = (state_d == S_SETUP) || (state_d == S_ACCESS);
    penable_d = (state_d == S_ACCESS);
  end

  // State and output registers
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q     <= S_IDLE;
      last_q      <= 1'b1;
      owner_q     <= 1'b0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      rsp_valid_q <= 2'b00;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      owner_q     <= owner_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

`ifdef APB_TIMEOUT_EN
  // ACCESS-phase stall counter
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end
`endif

  assign PSEL      = psel_q;
  assign PENABLE   = penable_q;
  assign PWRITE    = pwrite_q;
  assign PADDR     = paddr_q;
  assign PWDATA    = pwdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule
